// File: rtl/run_time_accumulator.sv
// Fan run-time accumulator: counts seconds of fan operation as hh:mm:ss plus a binary total,
// drives a BCD display word and a cleaning reminder, and clears on each toggle from self-clean.
module run_time_accumulator #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REMIND_SEC = 36_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  mode_state,
  input  logic        clear_accumulated_time,
  output logic [18:0] total_sec,
  output logic [31:0] time_data,
  output logic        reminder
);

  localparam int              PRE_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(CLK_HZ - 1);
  localparam logic [18:0]      TOTAL_MAX = 19'd359_999;

  logic [PRE_W-1:0] prescaler;
  logic [6:0]       hours;
  logic [5:0]       minutes;
  logic [5:0]       seconds;
  logic             clr_prev;

  logic running;
  logic sec_tick;
  logic clr_event;
  logic saturated;

  // Two BCD digits (tens, units) of a value in 0..99.
  function automatic logic [7:0] bcd2(input logic [6:0] v);
    logic [6:0] tens;
    logic [6:0] units;
    tens  = v / 7'd10;
    units = v % 7'd10;
    return {tens[3:0], units[3:0]};
  endfunction

  // True once the counters have reached 99:59:59; further ticks are ignored.
  function automatic logic at_limit(input logic [6:0] h, input logic [5:0] m,
                                    input logic [5:0] s);
    return (h == 7'd99) && (m == 6'd59) && (s == 6'd59);
  endfunction

  always_comb begin
    running   = (mode_state == 3'b001) || (mode_state == 3'b010) || (mode_state == 3'b011);
    sec_tick  = running && (prescaler == PRE_MAX);
    clr_event = clr_prev ^ clear_accumulated_time;
    saturated = at_limit(hours, minutes, seconds);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_prev <= 1'b0;
    end else begin
      clr_prev <= clear_accumulated_time;
    end
  end

  // Prescaler pauses (holds) while not running so partial seconds are not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler <= '0;
    end else if (clr_event) begin
      prescaler <= '0;
    end else if (running) begin
      if (prescaler == PRE_MAX) begin
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  // A clear event takes priority over a coincident second tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hours     <= '0;
      minutes   <= '0;
      seconds   <= '0;
      total_sec <= '0;
    end else if (clr_event) begin
      hours     <= '0;
      minutes   <= '0;
      seconds   <= '0;
      total_sec <= '0;
    end else if (sec_tick && !saturated) begin
      total_sec <= (total_sec == TOTAL_MAX) ? TOTAL_MAX : total_sec + 19'd1;
      if (seconds == 6'd59) begin
        seconds <= '0;
        if (minutes == 6'd59) begin
          minutes <= '0;
          hours   <= hours + 7'd1;
        end else begin
          minutes <= minutes + 6'd1;
        end
      end else begin
        seconds <= seconds + 6'd1;
      end
    end
  end

  always_comb begin
    time_data = {bcd2(hours), 4'hF, bcd2({1'b0, minutes}), 4'hF, bcd2({1'b0, seconds})};
    reminder  = (32'(total_sec) >= 32'(REMIND_SEC));
  end

endmodule

// File: doc/run_time_accumulator.md
RUN_TIME_ACCUMULATOR -- requirements
Module: run_time_accumulator

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, meaning clk cycles per counted second.
REQ-002 Parameter REMIND_SEC, default 36_000, meaning accumulated seconds at which the cleaning reminder asserts.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 mode_state  input  3  current operating mode; 3'b001/3'b010/3'b011 = fan running (levels 1-3); 3'b100 = self-clean; all other codes = not running.
REQ-006 clear_accumulated_time  input  1  toggle-type clear request from self-clean block; every change of level is one clear request.
REQ-007 total_sec  output  19  accumulated running time in seconds, binary.
REQ-008 time_data  output  32  display word: [31:28] hours tens, [27:24] hours units, [23:20] 4'hF, [19:16] minutes tens, [15:12] minutes units, [11:8] 4'hF, [7:4] seconds tens, [3:0] seconds units.
REQ-009 reminder  output  1  high when total_sec >= REMIND_SEC.

Function
REQ-010 Block SHALL hold a prescaler counter of width ceil(log2(CLK_HZ)) and hours (0-99), minutes (0-59), seconds (0-59) counters in binary.
REQ-011 Running = mode_state in {3'b001, 3'b010, 3'b011}.
REQ-012 While running, the prescaler SHALL increment by 1 per clk; at value CLK_HZ-1 it SHALL wrap to 0 and generate a one-cycle second tick.
REQ-013 While not running, the prescaler SHALL hold its value (pause, not clear); counting resumes from the held value when running returns.
REQ-014 On a second tick, seconds SHALL increment; 59 wraps to 0 with minutes +1; minutes 59 wraps to 0 with hours +1; total_sec +1 on the same edge.
REQ-015 At 99:59:59 (total_sec = 359_999) counters SHALL saturate; further ticks leave all counters unchanged.
REQ-016 Block SHALL register clear_accumulated_time into clr_prev each cycle; clr_prev != clear_accumulated_time is a clear event.
REQ-017 On a clear event, hours, minutes, seconds, total_sec and prescaler SHALL all be 0 on the next edge, regardless of mode.
REQ-018 Clear event and second tick on the same edge: clear SHALL win; result is all zero.
REQ-019 Two toggles on consecutive cycles SHALL yield two clear events; counters stay zero.
REQ-020 time_data SHALL be combinational from hours/minutes/seconds (digit = value/10, value%10); zero latency from counter registers.
REQ-021 reminder SHALL be combinational from total_sec; deasserts in the cycle after a clear event is applied.
REQ-022 mode 3'b100 SHALL NOT count and SHALL NOT clear by itself; only the toggle input clears.

Reset
REQ-023 While rst is low: prescaler, hours, minutes, seconds, total_sec = 0; clr_prev = 0; hence time_data = 32'h00F0_0F00 and reminder = 0.
REQ-024 Reset asserted mid-count SHALL clear immediately, without waiting for clk; release resumes counting from 0 on the first edge with rst high.

Verification (CLK_HZ=4, REMIND_SEC=5)
REQ-025 Reset, mode=3'b001 for 20 cycles -> total_sec=5, time_data=32'h00F0_0F05, reminder=1 on the edge total_sec reaches 5.
REQ-026 mode=3'b010 for 2 cycles, mode=3'b000 for 10 cycles, mode=3'b010 for 2 cycles -> exactly one tick, total_sec=1 (prescaler paused, not lost).
REQ-027 Preload 59 min 59 s of running (total_sec=3599), one more second -> time_data=32'h01F0_0F00, total_sec=3600.
REQ-028 Run to total_sec=7, toggle clear_accumulated_time 0->1 on the same edge as a tick -> total_sec=0, reminder=0, time_data=32'h00F0_0F00; next 4 running cycles -> total_sec=1.
REQ-029 Force to 99:59:59, run 8 more cycles -> total_sec stays 359_999, time_data=32'h99F5_9F59.
REQ-030 mode=3'b100 for 40 cycles with no toggle -> total_sec unchanged; drop rst for 1 ns between edges -> outputs zero immediately.
